// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the combinational 8-bit ALU: queues commands, issues one at a time,
// and registers each 16-bit result behind a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       cmd_valid_in,
    output logic                       cmd_ready_out,
    input  logic [2:0]                 cmd_op_in,
    input  logic [7:0]                 cmd_a_in,
    input  logic [7:0]                 cmd_b_in,
    output logic [7:0]                 alu_a_out,
    output logic [7:0]                 alu_b_out,
    output logic [2:0]                 alu_command_out,
    output logic                       alu_en_out,
    input  logic [15:0]                alu_d_in,
    output logic                       res_valid_out,
    input  logic                       res_ready_in,
    output logic [15:0]                res_data_out,
    output logic [2:0]                 res_op_out,
    output logic                       res_err_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_RESULT = 2'b10
    } state_t;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op > 3'b100);
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            pop_s;
    logic            push_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [18:0]     fifo_mem_r [DEPTH];
    logic [18:0]     head_s;
    logic            cmd_ready_r;
    logic [7:0]      alu_a_r;
    logic [7:0]      alu_b_r;
    logic [2:0]      alu_command_r;
    logic            alu_en_r;
    logic            res_valid_r;
    logic [15:0]     res_data_r;
    logic [2:0]      res_op_r;
    logic            res_err_r;

    assign push_s = cmd_valid_in & cmd_ready_r;
    assign head_s = fifo_mem_r[rd_ptr_r];

    // Next-state and pop decision; a pop only ever sees entries already counted in count_r.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready_in) begin
                    if (count_r != {CW{1'b0}}) begin
                        pop_s        = 1'b1;
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RESULT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy update for push, pop or both.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO pointers, count and the registered ready flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s < DEPTH_C);
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_op_in, cmd_a_in, cmd_b_in};
        end
    end

    // ALU drive registers: operands hold their last issued values between issues.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_a_r       <= 8'h00;
            alu_b_r       <= 8'h00;
            alu_command_r <= 3'b000;
            alu_en_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                alu_command_r <= head_s[18:16];
                alu_a_r       <= head_s[15:8];
                alu_b_r       <= head_s[7:0];
            end
            alu_en_r <= (state_next_s == ST_ISSUE);
        end
    end

    // Result capture during ISSUE and release on the downstream handshake.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 16'h0000;
            res_op_r    <= 3'b000;
            res_err_r   <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            res_valid_r <= 1'b1;
            res_data_r  <= alu_d_in;
            res_op_r    <= alu_command_r;
            res_err_r   <= op_is_illegal(alu_command_r);
        end else if ((state_r == ST_RESULT) && res_ready_in) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    assign cmd_ready_out   = cmd_ready_r;
    assign count_out       = count_r;
    assign alu_a_out       = alu_a_r;
    assign alu_b_out       = alu_b_r;
    assign alu_command_out = alu_command_r;
    assign alu_en_out      = alu_en_r;
    assign res_valid_out   = res_valid_r;
    assign res_data_out    = res_data_r;
    assign res_op_out      = res_op_r;
    assign res_err_out     = res_err_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached to its ALU port.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [2:0]  cmd_op_in;
    logic [7:0]  cmd_a_in;
    logic [7:0]  cmd_b_in;
    logic [7:0]  alu_a_out;
    logic [7:0]  alu_b_out;
    logic [2:0]  alu_command_out;
    logic        alu_en_out;
    logic [15:0] alu_d_in;
    logic        res_valid_out;
    logic        res_ready_in;
    logic [15:0] res_data_out;
    logic [2:0]  res_op_out;
    logic        res_err_out;
    logic [2:0]  count_out;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_a_in(cmd_a_in), .cmd_b_in(cmd_b_in),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_command_out(alu_command_out), .alu_en_out(alu_en_out),
        .alu_d_in(alu_d_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_data_out(res_data_out), .res_op_out(res_op_out),
        .res_err_out(res_err_out), .count_out(count_out)
    );

    // ALU semantics: zero-extended operands, 16-bit wrap, illegal ops give 0.
    function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {8'h00, a} + {8'h00, b};
            3'd1:    return {8'h00, a} - {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a | b};
            3'd4:    return ~{8'h00, a};
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_d_in = alu_en_out ? ref_result(alu_command_out, alu_a_out, alu_b_out) : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: records accepted commands and checks every result handshake against the queue.
    exp_t held;
    bit   stall_seen = 1'b0;
    bit   prev_en    = 1'b0;
    always @(negedge clk) begin
        if (rst_in) begin
            sb_q.delete();
            stall_seen = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (cmd_valid_in && cmd_ready_out) begin
                sb_q.push_back('{op: cmd_op_in, data: ref_result(cmd_op_in, cmd_a_in, cmd_b_in),
                                 err: (cmd_op_in > 3'd4)});
            end
            if (stall_seen) begin
                chk("stall_valid", 32'(res_valid_out), 32'd1);
                chk("stall_data", 32'(res_data_out), 32'(held.data));
                chk("stall_op", 32'(res_op_out), 32'(held.op));
            end
            if (res_valid_out && res_ready_in) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 32'(res_data_out), 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("res_data", 32'(res_data_out), 32'(e.data));
                    chk("res_op", 32'(res_op_out), 32'(e.op));
                    chk("res_err", 32'(res_err_out), 32'(e.err));
                end
            end
            stall_seen = res_valid_out && !res_ready_in;
            held       = '{op: res_op_out, data: res_data_out, err: res_err_out};
            if (prev_en && alu_en_out) begin
                chk("alu_en_one_cycle", 32'd2, 32'd1);
            end
            prev_en = alu_en_out;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit rnd);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        cmd_op_in    = op;
        cmd_a_in     = a;
        cmd_b_in     = b;
        cmd_valid_in = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = cmd_ready_out;
            @(posedge clk);
            #1;
            if (rnd) res_ready_in = ($urandom_range(0, 9) < 7);
            n++;
            if (!acc && n > 300) begin
                chk("send_timeout", 32'(n), 32'd0);
                acc = 1'b1;
            end
        end
        cmd_valid_in = 1'b0;
    endtask

    task automatic wait_drain(output int n);
        n = 0;
        while ((sb_q.size() != 0 || count_out != 3'd0 || res_valid_out) && n < 300) begin
            step(1);
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  acc;
        rst_in       = 1'b1;
        cmd_valid_in = 1'b0;
        cmd_op_in    = 3'd0;
        cmd_a_in     = 8'h00;
        cmd_b_in     = 8'h00;
        res_ready_in = 1'b1;
        step(3);
        rst_in = 1'b0;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_ready", 32'(cmd_ready_out), 32'd1);
        chk("rst_valid", 32'(res_valid_out), 32'd0);
        chk("rst_en", 32'(alu_en_out), 32'd0);
        chk("rst_alu", 32'({alu_a_out, alu_b_out, alu_command_out}), 32'd0);
        chk("rst_res", 32'({res_data_out, res_op_out, res_err_out}), 32'd0);

        // Latency of a single ADD.
        send(3'd0, 8'h05, 8'h03, 1'b0);
        chk("lat_n_valid", 32'(res_valid_out), 32'd0);
        chk("lat_n_en", 32'(alu_en_out), 32'd0);
        step(1);
        chk("lat_n1_en", 32'(alu_en_out), 32'd1);
        chk("lat_n1_ops", 32'({alu_command_out, alu_a_out, alu_b_out}), 32'({3'd0, 8'h05, 8'h03}));
        step(1);
        chk("lat_n2_valid", 32'(res_valid_out), 32'd1);
        chk("lat_n2_en", 32'(alu_en_out), 32'd0);
        chk("lat_n2_data", 32'(res_data_out), 32'h0008);
        wait_drain(n);

        // Mixed ops in order.
        send(3'd1, 8'h03, 8'h05, 1'b0);
        send(3'd4, 8'h0F, 8'h00, 1'b0);
        send(3'd2, 8'hF0, 8'h3C, 1'b0);
        send(3'd3, 8'hF0, 8'h0F, 1'b0);
        wait_drain(n);

        // Backpressure: fill the FIFO, refuse a sixth, then drain at one result per 2 cycles.
        res_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(3'(i % 5), 8'(8'h11 * i), 8'(8'h07 + i), 1'b0);
        chk("bp_count", 32'(count_out), 32'd4);
        chk("bp_ready", 32'(cmd_ready_out), 32'd0);
        cmd_op_in = 3'd0; cmd_a_in = 8'hAA; cmd_b_in = 8'h01; cmd_valid_in = 1'b1;
        step(3);
        cmd_valid_in = 1'b0;
        chk("bp_count_hold", 32'(count_out), 32'd4);
        res_ready_in = 1'b1;
        wait_drain(n);
        chk("drain_cycles", 32'(n), 32'd9);

        // Illegal op followed by ADD.
        send(3'd6, 8'hFF, 8'hFF, 1'b0);
        send(3'd0, 8'h01, 8'h02, 1'b0);
        wait_drain(n);

        // Simultaneous push/pop at count 2, then a rejected push at count 4.
        res_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) send(3'd0, 8'(i), 8'h10, 1'b0);
        step(2);
        chk("pp_pre_count", 32'(count_out), 32'd2);
        cmd_op_in = 3'd3; cmd_a_in = 8'h40; cmd_b_in = 8'h02; cmd_valid_in = 1'b1; res_ready_in = 1'b1;
        @(negedge clk); acc = cmd_ready_out;
        @(posedge clk); #1;
        cmd_valid_in = 1'b0; res_ready_in = 1'b0;
        chk("pp_accept", 32'(acc), 32'd1);
        chk("pp_count", 32'(count_out), 32'd2);
        send(3'd1, 8'h09, 8'h01, 1'b0);
        send(3'd2, 8'h0C, 8'h0A, 1'b0);
        step(2);
        chk("full_count", 32'(count_out), 32'd4);
        cmd_op_in = 3'd0; cmd_a_in = 8'h77; cmd_b_in = 8'h77; cmd_valid_in = 1'b1; res_ready_in = 1'b1;
        @(negedge clk); acc = cmd_ready_out;
        @(posedge clk); #1;
        cmd_valid_in = 1'b0; res_ready_in = 1'b0;
        chk("full_reject", 32'(acc), 32'd0);
        chk("full_pop_count", 32'(count_out), 32'd3);
        res_ready_in = 1'b1;
        wait_drain(n);

        // Reset while holding a result with 3 queued.
        res_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd0, 8'h20, 8'(i), 1'b0);
        step(3);
        chk("mr_pre_count", 32'(count_out), 32'd3);
        chk("mr_pre_valid", 32'(res_valid_out), 32'd1);
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        chk("mr_valid", 32'(res_valid_out), 32'd0);
        chk("mr_count", 32'(count_out), 32'd0);
        chk("mr_en", 32'(alu_en_out), 32'd0);
        chk("mr_ready", 32'(cmd_ready_out), 32'd1);
        res_ready_in = 1'b1;
        send(3'd0, 8'h30, 8'h0C, 1'b0);
        wait_drain(n);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 200; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    step(1);
                    res_ready_in = ($urandom_range(0, 9) < 7);
                end
            end
        end
        res_ready_in = 1'b1;
        wait_drain(n);
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
